// File: rtl/fetch_pkg.sv
// Shared types and line geometry for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RECV,
    DRAIN
  } fetch_state_t;

  localparam int LINE_BYTES     = 64;
  localparam int BEATS_PER_LINE = 8;
  localparam int INSTS_PER_LINE = 16;
  localparam int INST_WIDTH     = 32;

  localparam int BEAT_IDX_W     = $clog2(BEATS_PER_LINE);
  localparam int INST_IDX_W     = $clog2(INSTS_PER_LINE);
  localparam int LINE_OFFSET_W  = $clog2(LINE_BYTES);

endpackage

// File: rtl/fetch_line_buffer.sv
// One cache line of storage: written a bus beat at a time, read one
// instruction at a time (two instructions per beat, low half first).
module fetch_line_buffer
  import fetch_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wrEn,
  input  logic [BEAT_IDX_W-1:0] i_wrBeat,
  input  logic [DATA_W-1:0]     i_wrData,
  input  logic [INST_IDX_W-1:0] i_rdIdx,
  output logic [INST_WIDTH-1:0] o_rdInst
);

  logic [DATA_W-1:0] r_mem [BEATS_PER_LINE];
  logic [DATA_W-1:0] w_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BEATS_PER_LINE; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wrEn) begin
      r_mem[i_wrBeat] <= i_wrData;
    end
  end

  assign w_word   = r_mem[i_rdIdx[INST_IDX_W-1:1]];
  assign o_rdInst = i_rdIdx[0] ? w_word[63:32] : w_word[31:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: requests 64-byte lines, buffers the 8-beat burst and
// streams instructions to decode; redirects discard stale bursts safely.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                         BUS_DATA_WIDTH = 64,
  parameter int                         BUS_TAG_WIDTH  = 13,
  parameter logic [BUS_DATA_WIDTH-1:0]  RESET_PC       = 64'h0,
  parameter logic [BUS_TAG_WIDTH-1:0]   FETCH_TAG      = 13'h0
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      p_bus_reqcyc,
  input  logic                      p_bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] p_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  p_bus_reqtag,
  input  logic                      p_bus_respcyc,
  output logic                      p_bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] p_bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  p_bus_resptag,
  input  logic                      redirect,
  input  logic [BUS_DATA_WIDTH-1:0] redirect_pc,
  output logic                      inst_valid,
  input  logic                      inst_ready,
  output logic [INST_WIDTH-1:0]     inst,
  output logic [BUS_DATA_WIDTH-1:0] inst_pc
);

  localparam int AW         = BUS_DATA_WIDTH;
  localparam int LINE_NUM_W = AW - LINE_OFFSET_W;

  fetch_state_t          r_state, w_stateNext;
  logic [AW-1:0]         r_pc, w_pcNext;
  logic [AW-1:0]         r_reqAddr, w_reqAddrNext;
  logic                  r_discard, w_discardNext;
  logic [BEAT_IDX_W-1:0] r_beat, w_beatNext;
  logic [INST_IDX_W-1:0] r_idx, w_idxNext;

  logic [AW-1:0]         w_redirPc;
  logic [AW-1:0]         w_pcNextLine;
  logic [LINE_NUM_W-1:0] w_lineNum;
  logic [AW-1:0]         w_seqLine;
  logic                  w_beatAccept;
  logic                  w_instFire;
  logic                  w_lastBeat;
  logic [INST_WIDTH-1:0] w_bufInst;
  logic                  w_unused;

  assign w_redirPc    = {redirect_pc[AW-1:2], 2'b00};
  assign w_lineNum    = r_pc[AW-1:LINE_OFFSET_W] + LINE_NUM_W'(1);
  assign w_seqLine    = {w_lineNum, {LINE_OFFSET_W{1'b0}}};
  assign w_pcNextLine = {w_pcNext[AW-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
  assign w_beatAccept = (r_state == RECV) && p_bus_respcyc;
  assign w_instFire   = (r_state == DRAIN) && inst_ready;
  assign w_lastBeat   = (r_beat == BEAT_IDX_W'(BEATS_PER_LINE - 1));
  assign w_unused     = ^{p_bus_resptag, redirect_pc[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_reqAddr <= '0;
      r_discard <= 1'b0;
      r_beat    <= '0;
      r_idx     <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_pc      <= w_pcNext;
      r_reqAddr <= w_reqAddrNext;
      r_discard <= w_discardNext;
      r_beat    <= w_beatNext;
      r_idx     <= w_idxNext;
    end
  end

  // The request address is captured only when entering REQ so a redirect
  // during an unacknowledged request never changes the address on the bus.
  always_comb begin
    w_stateNext   = r_state;
    w_pcNext      = redirect ? w_redirPc : r_pc;
    w_reqAddrNext = r_reqAddr;
    w_discardNext = r_discard;
    w_beatNext    = r_beat;
    w_idxNext     = r_idx;
    case (r_state)
      IDLE: begin
        w_stateNext   = REQ;
        w_reqAddrNext = w_pcNextLine;
      end
      REQ: begin
        if (redirect) w_discardNext = 1'b1;
        if (p_bus_reqack) begin
          w_stateNext = RECV;
          w_beatNext  = '0;
        end
      end
      RECV: begin
        if (redirect) w_discardNext = 1'b1;
        if (w_beatAccept) begin
          w_beatNext = r_beat + BEAT_IDX_W'(1);
          if (w_lastBeat) begin
            if (r_discard || redirect) begin
              w_stateNext   = REQ;
              w_discardNext = 1'b0;
              w_reqAddrNext = w_pcNextLine;
            end else begin
              w_stateNext = DRAIN;
              w_idxNext   = r_pc[LINE_OFFSET_W-1:2];
            end
          end
        end
      end
      DRAIN: begin
        if (w_instFire) w_idxNext = r_idx + INST_IDX_W'(1);
        if (redirect) begin
          w_stateNext   = REQ;
          w_reqAddrNext = w_pcNextLine;
        end else if (w_instFire && (r_idx == INST_IDX_W'(INSTS_PER_LINE - 1))) begin
          w_stateNext   = REQ;
          w_pcNext      = w_seqLine;
          w_reqAddrNext = w_seqLine;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  fetch_line_buffer #(
    .DATA_W (BUS_DATA_WIDTH)
  ) u_lineBuffer (
    .clk      (clk),
    .reset    (reset),
    .i_wrEn   (w_beatAccept),
    .i_wrBeat (r_beat),
    .i_wrData (p_bus_resp),
    .i_rdIdx  (r_idx),
    .o_rdInst (w_bufInst)
  );

  assign p_bus_reqcyc  = (r_state == REQ);
  assign p_bus_req     = r_reqAddr;
  assign p_bus_reqtag  = FETCH_TAG;
  assign p_bus_respack = w_beatAccept;
  assign inst_valid    = (r_state == DRAIN);
  assign inst          = (r_state == DRAIN) ? w_bufInst : '0;
  assign inst_pc       = (r_state == DRAIN) ? {r_pc[AW-1:LINE_OFFSET_W], r_idx, 2'b00} : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural cache responder plus
// request/instruction scoreboards, a redirect vector table and corner cases.
module tb_fetch_unit;

  typedef struct {
    logic [63:0] redirPc;
    logic [63:0] expReq;
    int          nInsts;
    logic [63:0] expNextReq;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_bus_reqcyc;
  logic        p_bus_reqack;
  logic [63:0] p_bus_req;
  logic [12:0] p_bus_reqtag;
  logic        p_bus_respcyc;
  logic        p_bus_respack;
  logic [63:0] p_bus_resp;
  logic [12:0] p_bus_resptag;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;

  int checkCount = 0;
  int passCount  = 0;

  logic [63:0] reqQ[$];
  logic [63:0] instQ[$];

  int          cState = 0;
  int          cBeat = 0;
  int          waitCnt = 0;
  int          ackDelay = 2;
  bit          gapMode = 0;
  bit          lastAccepted = 0;
  logic [63:0] cAddr = '0;

  vec_t vecs[4];

  always #5 clk = ~clk;

  fetch_unit #(
    .BUS_DATA_WIDTH (64),
    .BUS_TAG_WIDTH  (13),
    .RESET_PC       (64'h1000),
    .FETCH_TAG      (13'h5A)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .p_bus_reqcyc  (p_bus_reqcyc),
    .p_bus_reqack  (p_bus_reqack),
    .p_bus_req     (p_bus_req),
    .p_bus_reqtag  (p_bus_reqtag),
    .p_bus_respcyc (p_bus_respcyc),
    .p_bus_respack (p_bus_respack),
    .p_bus_resp    (p_bus_resp),
    .p_bus_resptag (p_bus_resptag),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc)
  );

  // Instruction word the cache returns for a given byte address.
  function automatic logic [31:0] instVal(input logic [63:0] a);
    return a[31:0] ^ 32'hA5C3_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  task automatic failNow(input string name, input logic [63:0] actual);
    checkCount++;
    $display("[TB] FAIL %s: got %h with nothing expected", name, actual);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [63:0] pc);
    tick();
    redirect    = 1'b1;
    redirect_pc = pc;
    tick();
    redirect    = 1'b0;
  endtask

  task automatic pushInsts(input logic [63:0] startPc, input int n);
    logic [63:0] base;
    base = {startPc[63:2], 2'b00};
    for (int i = 0; i < n; i++) instQ.push_back(base + 64'(4 * i));
  endtask

  task automatic waitConsumed(input bit fullLine);
    for (int i = 0; i < 800 && instQ.size() != 0; i++) tick();
    checkOutput("inst queue drained", 64'(instQ.size()), 64'd0);
    if (fullLine) checkOutput("reqcyc after last inst", 64'(p_bus_reqcyc), 64'd1);
    inst_ready = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 400 && !(inst_valid && cState == 0); i++) tick();
    checkOutput("settle inst_valid", 64'(inst_valid), 64'd1);
    checkOutput("request queue drained", 64'(reqQ.size()), 64'd0);
  endtask

  task automatic driveBeat();
    p_bus_respcyc = gapMode ? ($urandom_range(0, 1) == 1) : 1'b1;
    p_bus_resp    = {instVal(cAddr + 64'(8 * cBeat + 4)), instVal(cAddr + 64'(8 * cBeat))};
  endtask

  // Behavioural cache: acks a request after ackDelay cycles, then streams 8 beats.
  initial begin
    logic [63:0] e;
    p_bus_reqack  = 1'b0;
    p_bus_respcyc = 1'b0;
    p_bus_resp    = '0;
    p_bus_resptag = 13'h5A;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        cState        = 0;
        cBeat         = 0;
        waitCnt       = 0;
        p_bus_reqack  = 1'b0;
        p_bus_respcyc = 1'b0;
      end else begin
        case (cState)
          0: if (p_bus_reqcyc) begin
            if (waitCnt >= ackDelay) begin
              p_bus_reqack = 1'b1;
              cState       = 1;
              cAddr        = p_bus_req;
              waitCnt      = 0;
              if (reqQ.size() == 0) failNow("unexpected request", cAddr);
              else begin
                e = reqQ.pop_front();
                checkOutput("request address", cAddr, e);
              end
            end else begin
              waitCnt++;
            end
          end
          1: begin
            p_bus_reqack = 1'b0;
            cState       = 2;
            cBeat        = 0;
            driveBeat();
          end
          default: begin
            if (lastAccepted) cBeat++;
            if (cBeat == 8) begin
              p_bus_respcyc = 1'b0;
              cState        = 0;
            end else begin
              driveBeat();
            end
          end
        endcase
      end
    end
  end

  // Mid-cycle monitor: beat acceptance and instruction scoreboard.
  always @(negedge clk) begin
    logic [63:0] e;
    if (reset) begin
      lastAccepted = 1'b0;
    end else begin
      lastAccepted = p_bus_respcyc && p_bus_respack;
      checkOutput("respack", 64'(p_bus_respack), 64'((cState == 2) && p_bus_respcyc));
      if (inst_valid && inst_ready) begin
        if (instQ.size() == 0) failNow("unexpected inst", inst_pc);
        else begin
          e = instQ.pop_front();
          checkOutput("inst_pc", inst_pc, e);
          checkOutput("inst", 64'(inst), 64'(instVal(e)));
        end
      end
    end
  end

  initial begin
    vecs[0] = '{redirPc: 64'h2034, expReq: 64'h2000, nInsts: 3, expNextReq: 64'h2040};
    vecs[1] = '{redirPc: 64'h5008, expReq: 64'h5000, nInsts: 14, expNextReq: 64'h5040};
    vecs[2] = '{redirPc: 64'h7FFF, expReq: 64'h7FC0, nInsts: 1, expNextReq: 64'h8000};
    vecs[3] = '{redirPc: 64'hFFFF_FFFF_FFFF_FFC0, expReq: 64'hFFFF_FFFF_FFFF_FFC0, nInsts: 16, expNextReq: 64'h0};

    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    inst_ready  = 1'b0;
    repeat (3) tick();

    checkOutput("reset reqcyc", 64'(p_bus_reqcyc), 64'd0);
    checkOutput("reset req", p_bus_req, 64'd0);
    checkOutput("reset reqtag", 64'(p_bus_reqtag), 64'h5A);
    checkOutput("reset respack", 64'(p_bus_respack), 64'd0);
    checkOutput("reset inst_valid", 64'(inst_valid), 64'd0);
    checkOutput("reset inst", 64'(inst), 64'd0);
    checkOutput("reset inst_pc", inst_pc, 64'd0);

    // First line after reset, then sequential prefetch of the next line.
    reqQ.push_back(64'h1000);
    reqQ.push_back(64'h1040);
    pushInsts(64'h1000, 16);
    reset = 1'b0;
    checkOutput("reqcyc idle cycle", 64'(p_bus_reqcyc), 64'd0);
    tick();
    checkOutput("first reqcyc", 64'(p_bus_reqcyc), 64'd1);
    checkOutput("first req", p_bus_req, 64'h1000);
    inst_ready = 1'b1;
    for (int i = 0; i < 100 && !(cState == 2 && cBeat == 7 && p_bus_respcyc); i++) tick();
    tick();
    checkOutput("valid after 8th beat", 64'(inst_valid), 64'd1);
    waitConsumed(1'b1);
    settle();

    // Redirect vectors issued while draining a line.
    for (int v = 0; v < 4; v++) begin
      reqQ.push_back(vecs[v].expReq);
      reqQ.push_back(vecs[v].expNextReq);
      pushInsts(vecs[v].redirPc, vecs[v].nInsts);
      applyStimulus(vecs[v].redirPc);
      inst_ready = 1'b1;
      waitConsumed(1'b1);
      settle();
    end

    // Redirect while a request is still waiting for its ack.
    ackDelay = 6;
    reqQ.push_back(64'h1000);
    reqQ.push_back(64'h3000);
    reqQ.push_back(64'h3040);
    pushInsts(64'h3000, 16);
    applyStimulus(64'h1000);
    tick();
    tick();
    applyStimulus(64'h3000);
    checkOutput("req held during REQ", p_bus_req, 64'h1000);
    checkOutput("reqcyc held during REQ", 64'(p_bus_reqcyc), 64'd1);
    ackDelay = 2;
    inst_ready = 1'b1;
    waitConsumed(1'b1);
    settle();

    // Two redirects during a burst: last target wins.
    reqQ.push_back(64'h4000);
    reqQ.push_back(64'h4500);
    reqQ.push_back(64'h4540);
    pushInsts(64'h4504, 15);
    applyStimulus(64'h4000);
    for (int i = 0; i < 100 && !(cState == 2 && cBeat == 4); i++) tick();
    tick();
    redirect    = 1'b1;
    redirect_pc = 64'h4480;
    tick();
    redirect_pc = 64'h4504;
    tick();
    redirect    = 1'b0;
    inst_ready  = 1'b1;
    waitConsumed(1'b1);
    settle();

    // Decode stalls: the presented instruction must hold.
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall inst_valid", 64'(inst_valid), 64'd1);
      checkOutput("stall inst_pc", inst_pc, 64'h4540);
      checkOutput("stall inst", 64'(inst), 64'(instVal(64'h4540)));
    end
    pushInsts(64'h4540, 2);
    inst_ready = 1'b1;
    waitConsumed(1'b0);
    tick();
    checkOutput("inst_pc after partial drain", inst_pc, 64'h4548);

    // Response beats with random gaps.
    gapMode = 1;
    reqQ.push_back(64'h6000);
    reqQ.push_back(64'h6040);
    pushInsts(64'h6000, 16);
    applyStimulus(64'h6000);
    inst_ready = 1'b1;
    waitConsumed(1'b1);
    settle();
    gapMode = 0;

    // Reset in the middle of a burst.
    reqQ.push_back(64'h8000);
    applyStimulus(64'h8000);
    for (int i = 0; i < 100 && !(cState == 2 && cBeat == 2); i++) tick();
    reset = 1'b1;
    #1;
    checkOutput("midburst reset reqcyc", 64'(p_bus_reqcyc), 64'd0);
    checkOutput("midburst reset respack", 64'(p_bus_respack), 64'd0);
    checkOutput("midburst reset inst_valid", 64'(inst_valid), 64'd0);
    checkOutput("midburst reset req", p_bus_req, 64'd0);
    tick();
    tick();
    reqQ.push_back(64'h1000);
    pushInsts(64'h1000, 2);
    reset = 1'b0;
    inst_ready = 1'b1;
    waitConsumed(1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
